// File: rtl/instr_controller.sv
// Instruction-register and sequencing FSM for a simple datapath.
// Captures an instruction word, decodes it and steps the datapath strobes one state per clock.
module instr_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        StWait, StDecode, StGetA, StGetB, StExec, StWriteImm, StWriteReg
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    logic       is_movi, is_movr, is_mvn, is_alu, is_cmp;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
    assign is_alu  = (opcode == 3'b101) && (op != 2'b11);
    assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);

    assign shift  = ir_q[4:3];
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        ir_d    = ir_q;
        state_d = state_q;
        case (state_q)
            StWait: begin
                if (load) ir_d = in;
                if (s) state_d = StDecode;
            end
            StDecode: begin
                if (is_movi)                state_d = StWriteImm;
                else if (is_movr || is_mvn) state_d = StGetB;
                else if (is_alu)            state_d = StGetA;
                else                        state_d = StWait;
            end
            StGetA:     state_d = StGetB;
            StGetB:     state_d = StExec;
            StExec:     state_d = is_cmp ? StWait : StWriteReg;
            StWriteImm: state_d = StWait;
            StWriteReg: state_d = StWait;
            default:    state_d = StWait;
        endcase
    end

    // Outputs are registered from the next state; the IR only changes on entry to
    // DECODE, where every strobe is idle, so decoding ir_q here is safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StWait;
            ir_q     <= '0;
            w        <= 1'b1;
            readnum  <= '0;
            writenum <= '0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            write    <= 1'b0;
            vsel     <= '0;
            ALUop    <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            w        <= (state_d == StWait);
            readnum  <= '0;
            writenum <= '0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            write    <= 1'b0;
            vsel     <= '0;
            ALUop    <= '0;
            case (state_d)
                StGetA: begin
                    readnum <= rn;
                    loada   <= 1'b1;
                end
                StGetB: begin
                    readnum <= rm;
                    loadb   <= 1'b1;
                end
                StExec: begin
                    asel  <= is_movr || is_mvn;
                    ALUop <= is_movr ? 2'b00 : op;
                    loadc <= !is_cmp;
                    loads <= is_cmp;
                end
                StWriteImm: begin
                    writenum <= rn;
                    vsel     <= 2'b01;
                    write    <= 1'b1;
                end
                StWriteReg: begin
                    writenum <= rd;
                    vsel     <= 2'b11;
                    write    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_controller.sv
// Bench for instr_controller: per-instruction expected-output sequences plus directed
// literal checks and a randomized run.
module tb_instr_controller;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, loada, loadb, loadc, loads, asel, bsel, write;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm5, sximm8;

    instr_controller dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .write(write),
        .vsel(vsel), .ALUop(ALUop), .shift(shift), .sximm5(sximm5), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        loada, loadb, loadc, loads, asel, bsel, write;
        logic [1:0]  vsel, alu_op, shift;
        logic [15:0] sximm5, sximm8;
    } obs_t;

    obs_t got;
    assign got = {w, readnum, writenum, loada, loadb, loadc, loads, asel, bsel, write,
                  vsel, ALUop, shift, sximm5, sximm8};

    int n_cmp = 0;
    int n_bad = 0;

    // Model: IR copy plus the remaining per-cycle output vectors of the running instruction.
    logic [15:0] m_ir = '0;
    obs_t        exp_q[$];
    bit          m_valid = 1'b0;

    task automatic push_seq(input logic [15:0] ir);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op;
        bit movi, movr, mvn, alu, cmp;
        obs_t z, v;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
        movi = (opc == 3'd6) && (op == 2'd2);
        movr = (opc == 3'd6) && (op == 2'd0);
        mvn  = (opc == 3'd5) && (op == 2'd3);
        alu  = (opc == 3'd5) && (op != 2'd3);
        cmp  = (opc == 3'd5) && (op == 2'd1);
        z = '0;
        exp_q.push_back(z);
        if (movi) begin
            v = z; v.writenum = rn; v.vsel = 2'b01; v.write = 1'b1;
            exp_q.push_back(v);
        end else if (movr || mvn || alu) begin
            if (alu) begin
                v = z; v.readnum = rn; v.loada = 1'b1;
                exp_q.push_back(v);
            end
            v = z; v.readnum = rm; v.loadb = 1'b1;
            exp_q.push_back(v);
            v = z; v.asel = movr || mvn; v.alu_op = movr ? 2'b00 : op;
            v.loadc = !cmp; v.loads = cmp;
            exp_q.push_back(v);
            if (!cmp) begin
                v = z; v.writenum = rd; v.vsel = 2'b11; v.write = 1'b1;
                exp_q.push_back(v);
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_ir = '0;
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else begin
            if (load) m_ir = in;
            if (s) push_seq(m_ir);
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        obs_t e;
        if (m_valid) begin
            if (exp_q.size() > 0) e = exp_q[0];
            else begin
                e = '0;
                e.w = 1'b1;
            end
            e.shift  = m_ir[4:3];
            e.sximm5 = {{11{m_ir[4]}}, m_ir[4:0]};
            e.sximm8 = {{8{m_ir[7]}}, m_ir[7:0]};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    obs_t tr [0:20];

    // Loads ir, pulses s, records outputs after each edge until w returns (bounded).
    task automatic run_instr(input logic [15:0] ir, output int lat);
        int k;
        @(negedge clk); reset = 1'b0; load = 1'b1; in = ir; s = 1'b0;
        @(negedge clk); load = 1'b0; s = 1'b1;
        @(negedge clk); s = 1'b0;
        k = 1;
        tr[1] = got;
        while (!got.w && k < 20) begin
            @(negedge clk);
            k++;
            tr[k] = got;
        end
        lat = k;
    endtask

    logic [15:0] lat_ir  [6] = '{16'hD007, 16'hC0E3, 16'hB845, 16'hA148, 16'hA801, 16'hE123};
    int          lat_exp [6] = '{3, 5, 5, 6, 5, 2};
    logic [4:0]  tops    [6] = '{5'b11010, 5'b11000, 5'b10111, 5'b10100, 5'b10101, 5'b10110};

    initial begin
        int lat, nw, nl;
        logic [31:0] r;
        reset = 1'b1; s = 1'b0; load = 1'b0; in = '0;
        repeat (2) @(negedge clk);
        chk("rst_w", w, 1);
        chk("rst_write", write, 0);
        chk("rst_loads", {loada, loadb, loadc, loads}, 0);
        chk("rst_ir", {sximm5, sximm8}, 0);

        run_instr(16'hD007, lat);
        chk("d007_lat", lat, 3);
        chk("d007_write", {tr[1].write, tr[2].write}, 2'b01);
        chk("d007_wb", {tr[2].writenum, tr[2].vsel}, {3'd0, 2'b01});
        chk("d007_imm8", tr[2].sximm8, 16'h0007);

        run_instr(16'hD1FE, lat);
        chk("d1fe_imm8", tr[2].sximm8, 16'hFFFE);
        chk("d1fe_wnum", tr[2].writenum, 1);

        run_instr(16'hA148, lat);
        chk("add_lat", lat, 6);
        chk("add_geta", {tr[2].readnum, tr[2].loada, tr[2].loadb}, {3'd1, 2'b10});
        chk("add_getb", {tr[3].readnum, tr[3].loada, tr[3].loadb}, {3'd0, 2'b01});
        chk("add_exec", {tr[4].asel, tr[4].bsel, tr[4].alu_op, tr[4].shift, tr[4].loadc},
            {2'b00, 2'b00, 2'b01, 1'b1});
        chk("add_wb", {tr[5].writenum, tr[5].vsel, tr[5].write}, {3'd2, 2'b11, 1'b1});

        run_instr(16'hA801, lat);
        nw = 0; nl = 0;
        for (int k = 1; k <= lat; k++) begin
            nw += int'(tr[k].write);
            nl += int'(tr[k].loads);
        end
        chk("cmp_lat", lat, 5);
        chk("cmp_loads_once", nl, 1);
        chk("cmp_loads_exec", tr[4].loads, 1);
        chk("cmp_no_write", nw, 0);

        for (int i = 0; i < 6; i++) begin
            run_instr(lat_ir[i], lat);
            chk($sformatf("lat_%h", lat_ir[i]), lat, lat_exp[i]);
        end

        // Reset during GET_B aborts the ADD.
        @(negedge clk); load = 1'b1; in = 16'hA148;
        @(negedge clk); load = 1'b0; s = 1'b1;
        @(negedge clk); s = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_getb", {loadb, readnum}, {1'b1, 3'd0});
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wait", w, 1);
        chk("abort_ir_clr", sximm8, 16'h0000);
        reset = 1'b0;
        nw = 0;
        repeat (6) begin
            @(negedge clk);
            nw += int'(write) + int'(loads);
        end
        chk("abort_no_write", nw, 0);

        // load while busy is ignored.
        @(negedge clk); load = 1'b1; in = 16'hD1FE;
        @(negedge clk); load = 1'b0; s = 1'b1;
        @(negedge clk); s = 1'b0; load = 1'b1; in = 16'h1234;
        @(negedge clk); load = 1'b0;
        chk("busy_wb", {write, writenum, sximm8}, {1'b1, 3'd1, 16'hFFFE});
        @(negedge clk);
        chk("busy_ir_kept", {w, sximm8}, {1'b1, 16'hFFFE});

        // Randomized run; the per-cycle model covers held s and overlapping load/s.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = $urandom;
            in = r[15:0];
            if ($urandom_range(3) != 0) in[15:11] = tops[$urandom_range(5)];
            reset = ($urandom_range(63) == 0);
            s     = ($urandom_range(1) == 1);
            load  = ($urandom_range(2) == 0);
        end
        @(negedge clk); reset = 1'b0; s = 1'b0; load = 1'b0;
        repeat (8) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_controller.md
INSTR_CONTROLLER -- requirements
Module: instr_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock shared with the datapath.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port s, input, 1 bit: start execution of the held instruction.
REQ-005 The block SHALL have port load, input, 1 bit: capture in into the instruction register (IR).
REQ-006 The block SHALL have port in, input, 16 bits: instruction word.
REQ-007 The block SHALL have port w, output, 1 bit: idle/ready, high only in WAIT.
REQ-008 The block SHALL have ports readnum and writenum, outputs, 3 bits each: datapath register selects.
REQ-009 The block SHALL have ports loada, loadb, loadc, loads, asel, bsel and write, outputs, 1 bit each: datapath strobes and selects.
REQ-010 The block SHALL have ports vsel, ALUop and shift, outputs, 2 bits each; vsel 00=mdata, 01=sximm8, 10=PC, 11=C.
REQ-011 The block SHALL have ports sximm5 and sximm8, outputs, 16 bits each: sign-extended IR[4:0] and IR[7:0].

Function
REQ-012 The IR SHALL decode as: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-013 The IR SHALL load at the clock edge when load=1 and the state is WAIT; load in any other state SHALL be ignored.
REQ-014 The FSM SHALL have the states WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_IMM and WRITE_REG.
REQ-015 From WAIT, the FSM SHALL go to DECODE when s=1 and stay in WAIT otherwise; if s=1 and load=1 at the same edge, the IR SHALL update and DECODE SHALL see the new IR.
REQ-016 From DECODE, the next state SHALL be: MOV imm (110/10) to WRITE_IMM; MOV reg (110/00) and MVN (101/11) to GET_B; ADD (101/00), CMP (101/01) and AND (101/10) to GET_A; any other encoding to WAIT.
REQ-017 GET_A SHALL go to GET_B, and GET_B SHALL go to EXEC.
REQ-018 From EXEC, CMP SHALL go to WAIT and all other instructions SHALL go to WRITE_REG.
REQ-019 WRITE_IMM and WRITE_REG SHALL go to WAIT.
REQ-020 Outputs SHALL be Moore outputs; any strobe not listed for a state SHALL be 0 in that state, and readnum/writenum SHALL be 0 where unused.
REQ-021 GET_A SHALL drive readnum=Rn, loada=1.
REQ-022 GET_B SHALL drive readnum=Rm, loadb=1.
REQ-023 EXEC SHALL drive bsel=0, with asel=1 for MOV reg/MVN and asel=0 otherwise.
REQ-024 EXEC SHALL drive ALUop=00 for MOV reg and op otherwise; it SHALL drive loadc=1 except for CMP, which SHALL drive loads=1 with loadc=0.
REQ-025 WRITE_IMM SHALL drive writenum=Rn, vsel=01, write=1.
REQ-026 WRITE_REG SHALL drive writenum=Rd, vsel=11, write=1.
REQ-027 shift SHALL equal sh, and sximm5/sximm8 SHALL be driven continuously from the IR.
REQ-028 Latency, counted in edges from the edge that samples s=1 until w=1 again: MOV imm 3, MOV reg/MVN 5, ADD/AND 6, CMP 5, undefined 2.
REQ-029 w SHALL be 1 in WAIT and 0 in every other state.
REQ-030 If s is held at 1, the FSM SHALL re-execute the IR immediately after returning to WAIT.

Reset
REQ-031 With reset=1 at an edge, the next state SHALL be WAIT and the IR SHALL be 16'h0000, taking priority over s and load.
REQ-032 After reset, w=1 and every other output SHALL be 0, except that sximm5 and sximm8 SHALL follow the cleared IR (0).
REQ-033 Reset asserted mid-instruction SHALL abort the instruction: no subsequent write or loads pulse SHALL occur.

Verification
REQ-034 The bench SHALL cover reset held for 2 cycles -> w=1, write=0, loada/loadb/loadc/loads=0, IR=0.
REQ-035 The bench SHALL cover load in=16'hD007, then s -> write=1 only in the 3rd cycle, with writenum=0, vsel=01, sximm8=16'h0007.
REQ-036 The bench SHALL cover in=16'hD1FE (MOV R1,#-2) -> sximm8=16'hFFFE and writenum=1 in WRITE_IMM.
REQ-037 The bench SHALL cover in=16'hA148 (ADD R2,R1,R0,LSL#1) -> this exact sequence, w=1 after the 6th edge:
- readnum=1/loada;
- readnum=0/loadb;
- asel=0, bsel=0, ALUop=00, shift=01, loadc;
- writenum=2, vsel=11, write.
REQ-038 The bench SHALL cover in=16'hA801 (CMP R0,R1) -> loads=1 for exactly one cycle in EXEC, write never 1, w=1 after the 5th edge.
REQ-039 The bench SHALL cover reset asserted during GET_B of 16'hA148 -> WAIT next cycle, write stays 0; separately, load=1 while busy -> IR unchanged.
